// File: rtl/vga_fill_engine.sv
// Rectangle-fill engine: APB slave register file plus an APB master that
// writes one framebuffer word per pixel in raster order over a clipped rectangle.
module vga_fill_engine #(
    parameter int unsigned FB_WIDTH  = 640,
    parameter int unsigned FB_HEIGHT = 480,
    parameter logic [31:0] FB_BASE   = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr,
    output logic        irq
);
    localparam int unsigned CW   = 12;
    localparam int unsigned CNTW = 20;
    localparam logic [CW-1:0] FB_W_C     = CW'(FB_WIDTH);
    localparam logic [CW-1:0] FB_H_C     = CW'(FB_HEIGHT);
    localparam logic [31:0]   ROW_STRIDE = 32'(FB_WIDTH);

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_X0     = 3'd2;
    localparam logic [2:0] REG_Y0     = 3'd3;
    localparam logic [2:0] REG_W      = 3'd4;
    localparam logic [2:0] REG_H      = 3'd5;
    localparam logic [2:0] REG_COLOR  = 3'd6;
    localparam logic [2:0] REG_PIXCNT = 3'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_e;

    state_e            state_q, state_d;
    logic [9:0]        x0_q, x0_d, y0_q, y0_d;
    logic [10:0]       w_q, w_d, h_q, h_d;
    logic [23:0]       color_q, color_d, scolor_q, scolor_d;
    logic              done_q, done_d, err_q, err_d, abort_q, abort_d;
    logic [CNTW-1:0]   pixcnt_q, pixcnt_d;
    logic [CW-1:0]     sx0_q, sx0_d, xe_q, xe_d, ye_q, ye_d;
    logic [CW-1:0]     cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [31:0]       line_q, line_d, paddr_q, paddr_d;
    logic              psel_q, psel_d, penable_q, penable_d;

    logic              wr_en, idle, start_wr, abort_wr, degenerate, last_x, last_px;
    logic [2:0]        reg_sel;
    logic [CW-1:0]     xe_sum, ye_sum;
    logic [31:0]       start_addr;
    logic              unused_inputs;

    assign unused_inputs = ^{in_pprot, in_pstrb, out_prdata, in_paddr[31:5],
                             in_paddr[1:0], in_pwdata[31:24]};

    assign reg_sel    = in_paddr[4:2];
    assign wr_en      = in_psel & in_penable & in_pwrite;
    assign idle       = (state_q == ST_IDLE);
    assign start_wr   = wr_en && (reg_sel == REG_CTRL) && in_pwdata[0];
    assign abort_wr   = wr_en && (reg_sel == REG_CTRL) && in_pwdata[1];
    assign xe_sum     = CW'(x0_q) + CW'(w_q);
    assign ye_sum     = CW'(y0_q) + CW'(h_q);
    assign degenerate = (w_q == 11'd0) || (h_q == 11'd0) ||
                        (CW'(x0_q) >= FB_W_C) || (CW'(y0_q) >= FB_H_C);
    assign start_addr = FB_BASE + 32'(y0_q) * ROW_STRIDE + 32'(x0_q);
    assign last_x     = (cur_x_q == xe_q - CW'(1));
    assign last_px    = last_x && (cur_y_q == ye_q - CW'(1));

    // Register file, start/abort handling and master FSM next state.
    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        w_d       = w_q;
        h_d       = h_q;
        color_d   = color_q;
        scolor_d  = scolor_q;
        done_d    = done_q;
        err_d     = err_q;
        abort_d   = abort_q;
        pixcnt_d  = pixcnt_q;
        sx0_d     = sx0_q;
        xe_d      = xe_q;
        ye_d      = ye_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        line_d    = line_q;
        paddr_d   = paddr_q;

        if (wr_en && (reg_sel == REG_STATUS)) begin
            if (in_pwdata[1]) done_d = 1'b0;
            if (in_pwdata[2]) err_d  = 1'b0;
        end
        if (wr_en && idle) begin
            case (reg_sel)
                REG_X0:    x0_d    = in_pwdata[9:0];
                REG_Y0:    y0_d    = in_pwdata[9:0];
                REG_W:     w_d     = in_pwdata[10:0];
                REG_H:     h_d     = in_pwdata[10:0];
                REG_COLOR: color_d = in_pwdata[23:0];
                default:   ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start_wr) begin
                    if (degenerate) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = ST_SETUP;
                        done_d   = 1'b0;
                        err_d    = 1'b0;
                        abort_d  = 1'b0;
                        pixcnt_d = '0;
                        sx0_d    = CW'(x0_q);
                        cur_x_d  = CW'(x0_q);
                        cur_y_d  = CW'(y0_q);
                        xe_d     = (xe_sum > FB_W_C) ? FB_W_C : xe_sum;
                        ye_d     = (ye_sum > FB_H_C) ? FB_H_C : ye_sum;
                        scolor_d = color_q;
                        line_d   = start_addr;
                        paddr_d  = start_addr;
                    end
                end
            end
            ST_SETUP: begin
                if (abort_wr) abort_d = 1'b1;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (abort_wr) abort_d = 1'b1;
                if (out_pready) begin
                    if (out_pslverr) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        abort_d = 1'b0;
                    end else begin
                        pixcnt_d = pixcnt_q + CNTW'(1);
                        if (last_px) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            abort_d = 1'b0;
                        end else if (abort_q || abort_wr) begin
                            state_d = ST_IDLE;
                            abort_d = 1'b0;
                        end else begin
                            state_d = ST_SETUP;
                            // Row wrap uses a running line start to avoid a multiplier per pixel.
                            if (last_x) begin
                                cur_x_d = sx0_q;
                                cur_y_d = cur_y_q + CW'(1);
                                line_d  = line_q + ROW_STRIDE;
                                paddr_d = line_q + ROW_STRIDE;
                            end else begin
                                cur_x_d = cur_x_q + CW'(1);
                                paddr_d = paddr_q + 32'd1;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        psel_d    = (state_d != ST_IDLE);
        penable_d = (state_d == ST_ACCESS);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            color_q   <= '0;
            scolor_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
            pixcnt_q  <= '0;
            sx0_q     <= '0;
            xe_q      <= '0;
            ye_q      <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            line_q    <= '0;
            paddr_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            w_q       <= w_d;
            h_q       <= h_d;
            color_q   <= color_d;
            scolor_q  <= scolor_d;
            done_q    <= done_d;
            err_q     <= err_d;
            abort_q   <= abort_d;
            pixcnt_q  <= pixcnt_d;
            sx0_q     <= sx0_d;
            xe_q      <= xe_d;
            ye_q      <= ye_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            line_q    <= line_d;
            paddr_q   <= paddr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    // Slave read mux is combinational from the register state.
    always_comb begin
        in_prdata = '0;
        case (reg_sel)
            REG_STATUS: in_prdata = {29'd0, err_q, done_q, !idle};
            REG_X0:     in_prdata = {22'd0, x0_q};
            REG_Y0:     in_prdata = {22'd0, y0_q};
            REG_W:      in_prdata = {21'd0, w_q};
            REG_H:      in_prdata = {21'd0, h_q};
            REG_COLOR:  in_prdata = {8'd0, color_q};
            REG_PIXCNT: in_prdata = {12'd0, pixcnt_q};
            default:    in_prdata = '0;
        endcase
    end

    assign in_pready   = 1'b1;
    assign in_pslverr  = 1'b0;
    assign out_paddr   = paddr_q;
    assign out_psel    = psel_q;
    assign out_penable = penable_q;
    assign out_pprot   = 3'd0;
    assign out_pwrite  = 1'b1;
    assign out_pwdata  = {8'd0, scolor_q};
    assign out_pstrb   = 4'hF;
    assign irq         = done_q;

endmodule

// File: tb/tb_vga_fill_engine.sv
// Directed self-checking bench for vga_fill_engine: models a framebuffer slave
// with programmable stalls/errors and checks transfers and register state.
module tb_vga_fill_engine;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_paddr = '0;
    logic        in_psel = 1'b0, in_penable = 1'b0, in_pwrite = 1'b0;
    logic [2:0]  in_pprot = '0;
    logic [31:0] in_pwdata = '0;
    logic [3:0]  in_pstrb = 4'hF;
    logic        in_pready, in_pslverr;
    logic [31:0] in_prdata;
    logic [31:0] out_paddr, out_pwdata, out_prdata = '0;
    logic        out_psel, out_penable, out_pwrite;
    logic [2:0]  out_pprot;
    logic [3:0]  out_pstrb;
    logic        out_pready = 1'b1, out_pslverr = 1'b0;
    logic        irq;

    int n_cmp = 0, n_fail = 0;
    int unsigned cyc = 0;
    int xfer_n = 0, stall_idx = -1, stall_left = 0, err_idx = -1, unstable = 0;
    bit psel_seen = 0, in_stall = 0;
    logic [31:0] hold_addr, hold_data;
    logic [31:0] q_addr[$], q_data[$];
    int unsigned q_cyc[$];

    vga_fill_engine dut (
        .clock(clock), .reset(reset),
        .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
        .in_pprot(in_pprot), .in_pwrite(in_pwrite), .in_pwdata(in_pwdata),
        .in_pstrb(in_pstrb), .in_pready(in_pready), .in_prdata(in_prdata),
        .in_pslverr(in_pslverr),
        .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
        .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
        .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr), .irq(irq)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Framebuffer slave model: answers ACCESS phases and logs completed writes.
    always @(negedge clock) begin
        if (out_psel) psel_seen = 1;
        if (out_psel && out_penable) begin
            if (in_stall && (out_paddr !== hold_addr || out_pwdata !== hold_data)) unstable++;
            if (!in_stall) begin hold_addr = out_paddr; hold_data = out_pwdata; end
            if (xfer_n == stall_idx && stall_left > 0) begin
                out_pready = 1'b0;
                stall_left--;
            end else begin
                out_pready = 1'b1;
            end
            out_pslverr = (xfer_n == err_idx);
            if (out_pready) begin
                q_addr.push_back(out_paddr);
                q_data.push_back(out_pwdata);
                q_cyc.push_back(cyc);
                xfer_n++;
            end
            in_stall = !out_pready;
        end else begin
            out_pready = 1'b1; out_pslverr = 1'b0; in_stall = 0;
        end
    end

    task automatic apb_write(input logic [2:0] idx, input logic [31:0] data);
        in_paddr = {27'd0, idx, 2'b00}; in_pwdata = data;
        in_pwrite = 1'b1; in_psel = 1'b1; in_penable = 1'b0;
        @(posedge clock); #1 in_penable = 1'b1;
        @(posedge clock); #1 in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [2:0] idx, output logic [31:0] data);
        @(negedge clock);
        in_paddr = {27'd0, idx, 2'b00};
        #1 data = in_prdata;
    endtask

    task automatic program_rect(input int x0, input int y0, input int w, input int h,
                                input logic [31:0] col);
        apb_write(3'd2, 32'(x0)); apb_write(3'd3, 32'(y0));
        apb_write(3'd4, 32'(w));  apb_write(3'd5, 32'(h));
        apb_write(3'd6, col);
    endtask

    task automatic clear_log();
        q_addr.delete(); q_data.delete(); q_cyc.delete();
        xfer_n = 0; stall_idx = -1; stall_left = 0; err_idx = -1; unstable = 0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        logic [31:0] s;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            apb_read(3'd1, s);
            if (!s[0]) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if ({out_psel, out_penable, irq} !== 3'b000) begin n_fail++;
            $display("FAIL reset_outputs got %b want 000", {out_psel, out_penable, irq}); end
        reset = 1'b1;
        for (int i = 1; i < 8; i++) begin
            apb_read(3'(i), r);
            n_cmp++; if (r !== 32'd0) begin n_fail++;
                $display("FAIL reset_reg%0d got %h want 0", i, r); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] r;
        bit ok;
        logic [31:0] exp_a [6] = '{32'd12810, 32'd12811, 32'd12812, 32'd13450, 32'd13451, 32'd13452};
        clear_log();
        program_rect(10, 20, 3, 2, 32'hABCDEF);
        apb_write(3'd0, 32'h1);
        apb_read(3'd1, r);
        n_cmp++; if (r !== 32'h1) begin n_fail++; $display("FAIL basic_busy got %h want 1", r); end
        wait_idle(100, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got busy want idle"); end
        n_cmp++; if (q_addr.size() != 6) begin n_fail++;
            $display("FAIL basic_count got %0d want 6", q_addr.size()); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (i >= q_addr.size() || q_addr[i] !== exp_a[i] || q_data[i] !== 32'h00ABCDEF) begin
                n_fail++;
                $display("FAIL basic_xfer%0d got %h/%h want %h/00abcdef", i,
                         (i < q_addr.size()) ? q_addr[i] : 32'hx,
                         (i < q_data.size()) ? q_data[i] : 32'hx, exp_a[i]);
            end
            if (i > 0 && i < q_cyc.size()) begin
                n_cmp++; if (q_cyc[i] - q_cyc[i-1] != 2) begin n_fail++;
                    $display("FAIL basic_gap%0d got %0d want 2", i, q_cyc[i] - q_cyc[i-1]); end
            end
        end
        apb_read(3'd1, r);
        n_cmp++; if (r !== 32'h2 || irq !== 1'b1) begin n_fail++;
            $display("FAIL basic_status got %h irq %b want 2 irq 1", r, irq); end
        apb_read(3'd7, r);
        n_cmp++; if (r !== 32'd6) begin n_fail++; $display("FAIL basic_pixcnt got %0d want 6", r); end
    endtask

    task automatic test_clip();
        logic [31:0] r;
        bit ok;
        clear_log();
        program_rect(638, 479, 5, 4, 32'h123456);
        apb_write(3'd0, 32'h1);
        wait_idle(100, ok);
        n_cmp++;
        if (!ok || q_addr.size() != 2 || q_addr[0] !== 32'd307198 || q_addr[1] !== 32'd307199) begin
            n_fail++;
            $display("FAIL clip_xfers got n=%0d first=%h want n=2 307198,307199", q_addr.size(),
                     (q_addr.size() > 0) ? q_addr[0] : 32'hx);
        end
        apb_read(3'd7, r);
        n_cmp++; if (r !== 32'd2) begin n_fail++; $display("FAIL clip_pixcnt got %0d want 2", r); end
    endtask

    task automatic test_degenerate();
        logic [31:0] r;
        clear_log();
        apb_write(3'd1, 32'h6);
        apb_read(3'd1, r);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL degen_clear got %h want 0", r); end
        psel_seen = 0;
        program_rect(5, 5, 0, 2, 32'h111111);
        apb_write(3'd0, 32'h1);
        apb_read(3'd1, r);
        n_cmp++; if (r !== 32'h2) begin n_fail++; $display("FAIL degen_w0_status got %h want 2", r); end
        apb_write(3'd1, 32'h6);
        program_rect(640, 5, 3, 2, 32'h111111);
        apb_write(3'd0, 32'h1);
        apb_read(3'd1, r);
        n_cmp++; if (r !== 32'h2) begin n_fail++; $display("FAIL degen_x640_status got %h want 2", r); end
        repeat (4) @(posedge clock);
        n_cmp++; if (psel_seen !== 1'b0) begin n_fail++; $display("FAIL degen_psel got 1 want 0"); end
    endtask

    task automatic test_stall();
        logic [31:0] r;
        bit ok;
        logic [31:0] exp_a [6] = '{32'd12810, 32'd12811, 32'd12812, 32'd13450, 32'd13451, 32'd13452};
        clear_log();
        program_rect(10, 20, 3, 2, 32'hABCDEF);
        stall_idx = 1; stall_left = 3;
        apb_write(3'd0, 32'h1);
        wait_idle(100, ok);
        n_cmp++; if (!ok || q_addr.size() != 6) begin n_fail++;
            $display("FAIL stall_count got %0d want 6", q_addr.size()); end
        for (int i = 0; i < 6 && i < q_addr.size(); i++) begin
            n_cmp++; if (q_addr[i] !== exp_a[i]) begin n_fail++;
                $display("FAIL stall_addr%0d got %0d want %0d", i, q_addr[i], exp_a[i]); end
        end
        n_cmp++; if (unstable != 0 || stall_left != 0) begin n_fail++;
            $display("FAIL stall_hold got unstable=%0d left=%0d want 0/0", unstable, stall_left); end
        n_cmp++;
        if (q_cyc.size() < 3 || q_cyc[1] - q_cyc[0] != 5 || q_cyc[2] - q_cyc[1] != 2) begin
            n_fail++; $display("FAIL stall_timing got gaps wrong want 5 then 2");
        end
        apb_read(3'd7, r);
        n_cmp++; if (r !== 32'd6) begin n_fail++; $display("FAIL stall_pixcnt got %0d want 6", r); end
    endtask

    task automatic test_slverr();
        logic [31:0] r;
        bit ok;
        clear_log();
        program_rect(10, 20, 3, 2, 32'hABCDEF);
        err_idx = 1;
        apb_write(3'd0, 32'h1);
        wait_idle(100, ok);
        apb_read(3'd1, r);
        n_cmp++; if (!ok || r !== 32'h6 || irq !== 1'b1) begin n_fail++;
            $display("FAIL slverr_status got %h irq %b want 6 irq 1", r, irq); end
        apb_read(3'd7, r);
        n_cmp++; if (r !== 32'd1) begin n_fail++; $display("FAIL slverr_pixcnt got %0d want 1", r); end
        psel_seen = 0;
        repeat (5) @(posedge clock);
        n_cmp++; if (psel_seen !== 1'b0 || q_addr.size() != 2) begin n_fail++;
            $display("FAIL slverr_stop got psel=%b n=%0d want 0/2", psel_seen, q_addr.size()); end
        err_idx = -1;
        apb_write(3'd1, 32'h6);
        apb_read(3'd1, r);
        n_cmp++; if (r !== 32'h0 || irq !== 1'b0) begin n_fail++;
            $display("FAIL slverr_clear got %h irq %b want 0 irq 0", r, irq); end
    endtask

    task automatic test_abort();
        logic [31:0] r;
        bit ok, hit;
        clear_log();
        program_rect(10, 20, 3, 2, 32'hABCDEF);
        apb_write(3'd0, 32'h1);
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clock); #1;
            hit = out_psel && out_penable && (xfer_n == 1);
        end
        n_cmp++; if (!hit) begin n_fail++; $display("FAIL abort_sync got no 2nd access want one"); end
        apb_write(3'd0, 32'h2);
        wait_idle(100, ok);
        n_cmp++; if (!ok || q_addr.size() != 3) begin n_fail++;
            $display("FAIL abort_count got %0d want 3", q_addr.size()); end
        apb_read(3'd1, r);
        n_cmp++; if (r !== 32'h0 || irq !== 1'b0) begin n_fail++;
            $display("FAIL abort_status got %h irq %b want 0 irq 0", r, irq); end
        apb_read(3'd7, r);
        n_cmp++; if (r !== 32'd3) begin n_fail++; $display("FAIL abort_pixcnt got %0d want 3", r); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        bit hit;
        clear_log();
        program_rect(10, 20, 3, 2, 32'hABCDEF);
        apb_write(3'd0, 32'h1);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clock); #1;
            hit = out_psel && out_penable;
        end
        reset = 1'b0;
        @(posedge clock); #1;
        n_cmp++; if (!hit || out_psel !== 1'b0 || out_penable !== 1'b0) begin n_fail++;
            $display("FAIL rstmid_psel got %b%b want 00", out_psel, out_penable); end
        reset = 1'b1;
        for (int i = 1; i < 8; i++) begin
            apb_read(3'(i), r);
            n_cmp++; if (r !== 32'd0) begin n_fail++;
                $display("FAIL rstmid_reg%0d got %h want 0", i, r); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_degenerate();
        test_stall();
        test_slverr();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
